// File: rtl/sdhci_dat_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : sdhci_dat_pkg
//  Description : Shared types and helpers for the SD data-path write staging.
//                This includes the write-buffer state encoding and the
//                byte-to-word conversion.
//  Revision    : 1.0 - initial release
// ============================================================================
package sdhci_dat_pkg;

   // Bytes carried by one host data-port word
   localparam int WordBytes = 4;

   // Write-buffer sequencing states
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FILL   = 3'd1,
      START  = 3'd2,
      SEND   = 3'd3,
      RESULT = 3'd4
   } dat_wbuf_state_e;

   // Number of 32-bit words needed to hold a block of the given byte count.
   // A partial last word counts as a whole word.
   function automatic logic [31:0] words_from_bytes(input logic [31:0] bytes);
      return (bytes + 32'(WordBytes - 1)) / 32'(WordBytes);
   endfunction

endpackage
`default_nettype wire

// File: rtl/dat_write_buffer_if.sv
`default_nettype none
// ============================================================================
//  Interface   : dat_write_buffer_if
//  Description : Control, host-word and dat_write handshake signals of the
//                write-data staging buffer. The slave modport is the buffer
//                itself. The master modport is the surrounding host/command
//                path and dat_write.
//  Revision    : 1.0 - initial release
// ============================================================================
interface dat_write_buffer_if #(
   parameter int MaxBlockBitSize = 12,
   parameter int BlockCountWidth = 16
);
   logic                       sd_clk_en_i;
   logic                       start_transfer_i;
   logic                       abort_i;
   logic [MaxBlockBitSize-1:0] block_size_i;
   logic [BlockCountWidth-1:0] block_count_i;
   logic                       wr_valid_i;
   logic [31:0]                wr_data_i;
   logic                       wr_ready_o;
   logic                       buffer_write_enable_o;
   logic                       dat_start_o;
   logic [31:0]                dat_data_o;
   logic                       dat_next_word_i;
   logic                       dat_done_i;
   logic                       dat_crc_err_i;
   logic                       dat_end_bit_err_i;
   logic                       xfer_complete_o;
   logic                       crc_err_o;
   logic                       end_bit_err_o;
   logic                       active_o;

   modport slave (
      input  sd_clk_en_i, start_transfer_i, abort_i, block_size_i, block_count_i,
      input  wr_valid_i, wr_data_i, dat_next_word_i, dat_done_i,
      input  dat_crc_err_i, dat_end_bit_err_i,
      output wr_ready_o, buffer_write_enable_o, dat_start_o, dat_data_o,
      output xfer_complete_o, crc_err_o, end_bit_err_o, active_o
   );

   modport master (
      output sd_clk_en_i, start_transfer_i, abort_i, block_size_i, block_count_i,
      output wr_valid_i, wr_data_i, dat_next_word_i, dat_done_i,
      output dat_crc_err_i, dat_end_bit_err_i,
      input  wr_ready_o, buffer_write_enable_o, dat_start_o, dat_data_o,
      input  xfer_complete_o, crc_err_o, end_bit_err_o, active_o
   );
endinterface
`default_nettype wire

// File: rtl/dat_block_ram.sv
`default_nettype none
// ============================================================================
//  Module      : dat_block_ram
//  Description : Block store with one synchronous write port and one
//                registered read port. A read of the address being written
//                in the same cycle returns the new data.
//  Revision    : 1.0 - initial release
// ============================================================================
module dat_block_ram #(
   parameter int WORDS = 128,
   parameter int WIDTH = 32
) (
   input  wire logic                     clk,
   input  wire logic                     rst,
   input  wire logic                     i_we,
   input  wire logic [$clog2(WORDS)-1:0] i_waddr,
   input  wire logic [WIDTH-1:0]         i_wdata,
   input  wire logic [$clog2(WORDS)-1:0] i_raddr,
   output logic      [WIDTH-1:0]         o_rdata
);

   logic [WIDTH-1:0] r_mem [WORDS];
   logic [WIDTH-1:0] r_rdata;

   // Storage array: plain synchronous write, no reset needed on the contents
   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   // Registered read with write-first bypass so a just-written word is visible
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rdata <= '0;
      end else if (i_we && (i_waddr == i_raddr)) begin
         r_rdata <= i_wdata;
      end else begin
         r_rdata <= r_mem[i_raddr];
      end
   end

   assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/dat_write_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : dat_write_buffer
//  Description : Host-side write-data staging ahead of dat_write. The module
//                collects one block of host words and starts dat_write. It
//                then serves the words on next-word requests, sequences
//                multi-block transfers and reports completion or errors.
//  Revision    : 1.0 - initial release
// ============================================================================
module dat_write_buffer
   import sdhci_dat_pkg::*;
#(
   parameter int MaxBlockBitSize = 12,
   parameter int BufferWords     = 128,
   parameter int BlockCountWidth = 16
) (
   input  wire logic          clk_i,
   input  wire logic          rst_i,
   dat_write_buffer_if.slave  bus
);

   localparam int c_PTR_W = $clog2(BufferWords);
   localparam logic [MaxBlockBitSize-1:0] c_WORD_ONE  = MaxBlockBitSize'(1);
   localparam logic [BlockCountWidth-1:0] c_BLOCK_ONE = BlockCountWidth'(1);
   localparam logic [c_PTR_W-1:0]         c_PTR_ONE   = c_PTR_W'(1);

   dat_wbuf_state_e            r_state;
   logic [MaxBlockBitSize-1:0] r_words_needed;
   logic [BlockCountWidth-1:0] r_blocks_left;
   logic [c_PTR_W-1:0]         r_wr_ptr;
   logic [c_PTR_W-1:0]         r_rd_ptr;
   logic                       r_crc_q;
   logic                       r_end_q;
   logic                       r_wr_ready;
   logic                       r_dat_start;
   logic                       r_xfer_complete;
   logic                       r_crc_err;
   logic                       r_end_bit_err;
   logic                       r_active;

   logic [MaxBlockBitSize-1:0] w_words_in;
   logic                       w_start_ok;
   logic                       w_wr_accept;
   logic                       w_last_word;
   logic                       w_rd_last;
   logic [31:0]                w_rd_data;

   // Decode of the start request and the block-boundary conditions
   always_comb begin
      w_words_in  = MaxBlockBitSize'(words_from_bytes(32'(bus.block_size_i)));
      w_start_ok  = bus.start_transfer_i
                    && (bus.block_size_i  != '0)
                    && (bus.block_count_i != '0);
      w_wr_accept = (r_state == FILL) && bus.wr_valid_i && !bus.abort_i;
      w_last_word = ((MaxBlockBitSize'(r_wr_ptr) + c_WORD_ONE) == r_words_needed);
      w_rd_last   = (MaxBlockBitSize'(r_rd_ptr) == (r_words_needed - c_WORD_ONE));
   end

   // Block store: written from the host side, read toward dat_write
   dat_block_ram #(
      .WORDS (BufferWords),
      .WIDTH (32)
   ) u_store (
      .clk     (clk_i),
      .rst     (rst_i),
      .i_we    (w_wr_accept),
      .i_waddr (r_wr_ptr),
      .i_wdata (bus.wr_data_i),
      .i_raddr (r_rd_ptr),
      .o_rdata (w_rd_data)
   );

   // Transfer sequencer with registered handshake, status and result pulses
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state         <= IDLE;
         r_words_needed  <= '0;
         r_blocks_left   <= '0;
         r_wr_ptr        <= '0;
         r_rd_ptr        <= '0;
         r_crc_q         <= 1'b0;
         r_end_q         <= 1'b0;
         r_wr_ready      <= 1'b0;
         r_dat_start     <= 1'b0;
         r_xfer_complete <= 1'b0;
         r_crc_err       <= 1'b0;
         r_end_bit_err   <= 1'b0;
         r_active        <= 1'b0;
      end else begin
         // Result outputs are single-cycle pulses
         r_xfer_complete <= 1'b0;
         r_crc_err       <= 1'b0;
         r_end_bit_err   <= 1'b0;

         if (bus.abort_i) begin
            // Abort overrides everything, including a same-cycle done
            r_state     <= IDLE;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_crc_q     <= 1'b0;
            r_end_q     <= 1'b0;
            r_wr_ready  <= 1'b0;
            r_dat_start <= 1'b0;
            r_active    <= 1'b0;
         end else begin
            case (r_state)
               IDLE: begin
                  if (w_start_ok) begin
                     r_words_needed <= w_words_in;
                     r_blocks_left  <= bus.block_count_i;
                     r_wr_ptr       <= '0;
                     r_rd_ptr       <= '0;
                     r_wr_ready     <= 1'b1;
                     r_active       <= 1'b1;
                     r_state        <= FILL;
                  end
               end

               FILL: begin
                  if (bus.wr_valid_i) begin
                     r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
                     if (w_last_word) begin
                        r_wr_ready  <= 1'b0;
                        r_dat_start <= 1'b1;
                        r_rd_ptr    <= '0;
                        r_state     <= START;
                     end
                  end
               end

               START: begin
                  // dat_write samples start only on an SD clock-enable cycle
                  if (bus.sd_clk_en_i) begin
                     r_dat_start <= 1'b0;
                     r_state     <= SEND;
                  end
               end

               SEND: begin
                  // Saturate on the last word to absorb the trailing request
                  if (bus.dat_next_word_i && !w_rd_last) begin
                     r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
                  end
                  if (bus.dat_done_i) begin
                     r_crc_q <= bus.dat_crc_err_i;
                     r_end_q <= bus.dat_end_bit_err_i;
                     r_state <= RESULT;
                  end
               end

               RESULT: begin
                  r_crc_q <= 1'b0;
                  r_end_q <= 1'b0;
                  if (r_crc_q || r_end_q) begin
                     r_crc_err     <= r_crc_q;
                     r_end_bit_err <= r_end_q;
                     r_active      <= 1'b0;
                     r_state       <= IDLE;
                  end else if (r_blocks_left == c_BLOCK_ONE) begin
                     r_xfer_complete <= 1'b1;
                     r_active        <= 1'b0;
                     r_state         <= IDLE;
                  end else begin
                     r_blocks_left <= r_blocks_left - c_BLOCK_ONE;
                     r_wr_ptr      <= '0;
                     r_rd_ptr      <= '0;
                     r_wr_ready    <= 1'b1;
                     r_state       <= FILL;
                  end
               end

               default: begin
                  r_wr_ready  <= 1'b0;
                  r_dat_start <= 1'b0;
                  r_active    <= 1'b0;
                  r_state     <= IDLE;
               end
            endcase
         end
      end
   end

   assign bus.wr_ready_o            = r_wr_ready;
   assign bus.buffer_write_enable_o = r_wr_ready;
   assign bus.dat_start_o           = r_dat_start;
   assign bus.dat_data_o            = w_rd_data;
   assign bus.xfer_complete_o       = r_xfer_complete;
   assign bus.crc_err_o             = r_crc_err;
   assign bus.end_bit_err_o         = r_end_bit_err;
   assign bus.active_o              = r_active;

endmodule
`default_nettype wire
